// File: rtl/sha_output_manager.sv
// sha_output_manager: registers the found-bitmap of all SHA cores and the
// nonce of the lowest-index core that reports a golden nonce.
module sha_output_manager #(
    parameter int NUM_CORES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [33*NUM_CORES-1:0] data_in,
    output logic [NUM_CORES-1:0]   flag,
    output logic [31:0]            golden_nonce
);
    logic [NUM_CORES-1:0] found;
    logic [31:0]          nonce;
    // Scan from the top down so the lowest-index asserting core overwrites last.
    always_comb begin
        found = '0;
        nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            found[i] = data_in[33*i+32];
            nonce    = data_in[33*i+32] ? data_in[33*i +: 32] : nonce;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag         <= '0;
            golden_nonce <= '0;
        end else if (enable) begin
            flag         <= found;
            golden_nonce <= nonce;
        end
    end
endmodule

// File: tb/tb_sha_output_manager.sv
// tb_sha_output_manager: directed checks of selection, hold, and async reset
// for a two-core sha_output_manager.
module tb_sha_output_manager;
    logic        tb_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [65:0] data_in;
    logic [1:0]  flag;
    logic [31:0] golden_nonce;
    int checks = 0;
    int failures = 0;

    sha_output_manager #(.NUM_CORES(2)) dut (
        .clk(tb_clk), .rst(rst), .enable(enable), .data_in(data_in),
        .flag(flag), .golden_nonce(golden_nonce)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; data_in = {33'd4294967299, 33'd4294967297};
        #1;
        checks++;
        if (flag !== 2'b00) begin failures++; $display("FAIL reset_flag got=%b exp=%b", flag, 2'b00); end
        checks++;
        if (golden_nonce !== 32'd0) begin failures++; $display("FAIL reset_nonce got=%0d exp=0", golden_nonce); end
        step();
        checks++;
        if (flag !== 2'b00 || golden_nonce !== 32'd0) begin
            failures++; $display("FAIL reset_hold_edge got=%b/%0d exp=00/0", flag, golden_nonce);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_not_found();
        data_in = 66'd2730;
        step();
        checks++;
        if (flag !== 2'b00 || golden_nonce !== 32'd0) begin
            failures++; $display("FAIL not_found got=%b/%0d exp=00/0", flag, golden_nonce);
        end
    endtask

    task automatic test_core0();
        data_in = 66'd4294967297;
        step();
        checks++;
        if (flag !== 2'b01 || golden_nonce !== 32'd1) begin
            failures++; $display("FAIL core0 got=%b/%0d exp=01/1", flag, golden_nonce);
        end
    endtask

    task automatic test_core1();
        data_in = {33'd4294967299, 33'd0};
        step();
        checks++;
        if (flag !== 2'b10 || golden_nonce !== 32'd3) begin
            failures++; $display("FAIL core1 got=%b/%0d exp=10/3", flag, golden_nonce);
        end
        data_in = {1'b1, 32'd7, 1'b0, 32'hDEADBEEF};
        step();
        checks++;
        if (flag !== 2'b10 || golden_nonce !== 32'd7) begin
            failures++; $display("FAIL core1_masked got=%b/%0h exp=10/7", flag, golden_nonce);
        end
    endtask

    task automatic test_zero();
        data_in = 66'd0;
        step();
        checks++;
        if (flag !== 2'b00 || golden_nonce !== 32'd0) begin
            failures++; $display("FAIL zero got=%b/%0d exp=00/0", flag, golden_nonce);
        end
    endtask

    task automatic test_both_hold();
        data_in = {1'b1, 32'd9, 1'b1, 32'd5};
        step();
        checks++;
        if (flag !== 2'b11 || golden_nonce !== 32'd5) begin
            failures++; $display("FAIL both got=%b/%0d exp=11/5", flag, golden_nonce);
        end
        enable = 1'b0; data_in = 66'd0;
        step();
        step();
        checks++;
        if (flag !== 2'b11 || golden_nonce !== 32'd5) begin
            failures++; $display("FAIL hold got=%b/%0d exp=11/5", flag, golden_nonce);
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        data_in = {1'b1, 32'hFFFFFFFF, 1'b0, 32'd0};
        step();
        checks++;
        if (flag !== 2'b10 || golden_nonce !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL b2b_first got=%b/%0h exp=10/ffffffff", flag, golden_nonce);
        end
        data_in = {1'b0, 32'd4, 1'b1, 32'd12};
        step();
        checks++;
        if (flag !== 2'b01 || golden_nonce !== 32'd12) begin
            failures++; $display("FAIL b2b_second got=%b/%0d exp=01/12", flag, golden_nonce);
        end
    endtask

    task automatic test_async_reset();
        data_in = 66'd4294967297;
        step();
        checks++;
        if (flag !== 2'b01 || golden_nonce !== 32'd1) begin
            failures++; $display("FAIL pre_reset got=%b/%0d exp=01/1", flag, golden_nonce);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (flag !== 2'b00 || golden_nonce !== 32'd0) begin
            failures++; $display("FAIL async_reset got=%b/%0d exp=00/0", flag, golden_nonce);
        end
        step();
        checks++;
        if (flag !== 2'b00 || golden_nonce !== 32'd0) begin
            failures++; $display("FAIL reset_priority got=%b/%0d exp=00/0", flag, golden_nonce);
        end
        #2 rst = 1'b0;
        step();
        checks++;
        if (flag !== 2'b01 || golden_nonce !== 32'd1) begin
            failures++; $display("FAIL post_reset got=%b/%0d exp=01/1", flag, golden_nonce);
        end
    endtask

    initial begin
        test_reset();
        test_not_found();
        test_core0();
        test_core1();
        test_zero();
        test_both_hold();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha_output_manager.md
SHA_OUTPUT_MANAGER -- requirements
Module: sha_output_manager

Interface
REQ-001 Parameter NUM_CORES, default 2: number of SHA256 cores monitored; legal range 1..32.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 Port enable, input, 1 bit: when 1, the registers update each cycle; when 0, all outputs hold.
REQ-005 Port data_in, input, 33*NUM_CORES bits: one 33-bit slice per core; core k occupies bits [33k+32:33k].
REQ-006 Port flag, output, NUM_CORES bits: registered found-bitmap; bit k set means core k reported a golden nonce.
REQ-007 Port golden_nonce, output, 32 bits: registered nonce of the selected core, or zero when no core reports.

Function
REQ-008 Slice format: bit 33k+32 is the found bit of core k; bits [33k+31:33k] are the candidate nonce of core k.
REQ-009 Next flag: bit k equals the found bit of core k, sampled from data_in at the clock edge.
REQ-010 Selection: the lowest-index core with its found bit set is the selected core (fixed priority, core 0 highest).
REQ-011 Next golden_nonce: the 32-bit nonce field of the selected core.
REQ-012 When no found bit is set, next golden_nonce is 32'd0 and next flag is all zeros, regardless of nonce-field contents.
REQ-013 Nonce fields of cores whose found bit is 0 never reach golden_nonce.
REQ-014 Latency: one clock; a data_in change before rising edge N appears on flag and golden_nonce after edge N.
REQ-015 Outputs are driven only from registers; there is no combinational path from data_in to outputs.
REQ-016 Multiple simultaneous found bits:
- flag shows every asserting core.
- golden_nonce takes the lowest-index core's nonce.
REQ-017 With enable=0, flag and golden_nonce keep their previous values; data_in is ignored.
REQ-018 There is no accumulation: each enabled edge fully replaces both outputs with the current-cycle result, with no sticky bits.
REQ-019 Selection logic is a parameterised priority scan over NUM_CORES slices; no core count is hard-coded.

Reset
REQ-020 When rst=1, flag is forced to all zeros and golden_nonce to 32'd0 immediately, with no clock required.
REQ-021 While rst=1, outputs stay zero regardless of enable or data_in.
REQ-022 Reset has priority over enable.
REQ-023 After rst deasserts, the first rising edge with enable=1 loads the normal next values.
REQ-024 Reset asserted mid-operation discards the current result; no output value survives reset.

Verification
REQ-025 NUM_CORES=2, enable=1, data_in=66'd2730 (found bits 0, nonce 2730 in core 0) -> after the next edge: flag=2'b00, golden_nonce=0.
REQ-026 data_in=66'd4294967297 (core 0 found, nonce 1) -> after the next edge: flag=2'b01, golden_nonce=1.
REQ-027 data_in={33'd4294967299, 33'd0} (core 1 found, nonce 3) -> after the next edge: flag=2'b10, golden_nonce=3.
REQ-028 data_in=66'd0 -> after the next edge: flag=2'b00, golden_nonce=0.
REQ-029 Both cores found, core 0 nonce 5 and core 1 nonce 9 -> flag=2'b11, golden_nonce=5; then enable=0 with data_in=0 -> outputs stay 2'b11 and 5.
REQ-030 Outputs hold flag=2'b01 and golden_nonce=1; assert rst between clock edges -> both outputs read zero before the next edge.
